usb_send_arb: RTL and testbench
===============================

USB_SEND_ARB -- requirements
Module: usb_send_arb

Interface
REQ-001 Parameters: NUM=8, channel count, fixed; TMO=16'd50000, watchdog limit in clk cycles, used only with ARB_TIMEOUT_EN.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 fs_req  input  8  per-channel send start flag; bit i owned by requester i.
REQ-005 fd_req  output  8  per-channel send done flag back to requester i.
REQ-006 req_btype  input  32  per-channel block type; channel i at bits [4i+3:4i].
REQ-007 fs_send  output  1  start flag to shared com send path.
REQ-008 fd_send  input  1  done flag from shared com send path.
REQ-009 send_btype  output  4  block type presented to com send path.
REQ-010 grant_idx  output  3  index of currently or last granted channel.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 tmo_err  output  1  one-cycle pulse on watchdog abort; tied 0 without ARB_TIMEOUT_EN.

Function
REQ-013 All handshakes are four-phase: fs rises, fd rises, fs falls, fd falls; no new fs until fd is low.
REQ-014 FSM states: IDLE, LOCK, SEND, ACK, REL.
REQ-015 IDLE: if any fs_req bit is high, the first set bit at or after ptr, wrapping 7->0, is selected; go to LOCK next cycle.
REQ-016 LOCK: latch grant_idx and send_btype from that channel's req_btype; go to SEND.
REQ-017 SEND: fs_send=1; on fd_send=1 go to ACK (fs_send drops the following cycle).
REQ-018 ACK: fs_send=0; fd_req[grant_idx]=1; wait until fd_send=0 and fs_req[grant_idx]=0, then go to REL.
REQ-019 REL: fd_req all 0; ptr=grant_idx+1, mod 8; go to IDLE.
REQ-020 Latency: fs_req rise in IDLE -> fs_send high after exactly 2 cycles.
REQ-021 Only fd_req[grant_idx] may be high, and only in ACK; other bits stay 0.
REQ-022 send_btype and grant_idx are stable from LOCK through REL; req_btype changes after LOCK are ignored.
REQ-023 Requests arriving while busy are held pending and are not lost; fairness: each requesting channel is served within 8 grants.
REQ-024 Requester dropping fs_req during SEND is ignored; the transfer completes.
REQ-025 fd_send high while in IDLE or LOCK is ignored.
REQ-026 Simultaneous requests: lowest index at or after ptr wins.

Reset
REQ-027 On rst=1 at a clk edge: state=IDLE, ptr=0, grant_idx=0, send_btype=0, fs_send=0, fd_req=0, busy=0, tmo_err=0, watchdog counter=0.
REQ-028 Reset mid-transfer aborts immediately: fs_send and fd_req are low in the cycle after the reset edge, with no completion to the requester.

Configuration
REQ-029 Macro ARB_TIMEOUT_EN defined: a 16-bit counter runs in SEND, clearing on entry. If it reaches TMO without fd_send, the block pulses tmo_err for 1 cycle, drops fs_send, sets no fd_req, sets ptr=grant_idx+1 and returns to IDLE.
REQ-030 Macro ARB_TIMEOUT_EN undefined: no counter; SEND waits indefinitely; tmo_err is constant 0.

Verification
REQ-031 fs_req=8'h04, req_btype[11:8]=4'h5 -> fs_send high 2 cycles later, send_btype=5, grant_idx=2; fd_send high -> fd_req=8'h04; release -> busy=0, ptr=3.
REQ-032 fs_req=8'h81 held, ptr=0 -> grant order 0,7,0,7 over 4 transfers.
REQ-033 ptr=3, fs_req=8'h09 -> channel 3 granted first, then channel 0.
REQ-034 rst pulsed while in SEND with grant_idx=4 -> next cycle fs_send=0, fd_req=0, busy=0, grant_idx=0.
REQ-035 With ARB_TIMEOUT_EN, TMO=16: fd_send held 0 -> tmo_err pulses 16 cycles after SEND entry, fs_send=0, fd_req=0, state IDLE.
REQ-036 fd_send held high and fs_req[1] held high in ACK -> remains in ACK with fd_req[1]=1; REL is entered only after both are low.

Source files
------------

// File: rtl/usb_send_arb.sv
// Round-robin arbiter letting NUM four-phase requesters share one com send path.
// Optional watchdog on the SEND phase is enabled by defining ARB_TIMEOUT_EN.
module usb_send_arb #(
  parameter int          NUM = 8,
  parameter logic [15:0] TMO = 16'd50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM-1:0]          fs_req,
  output logic [NUM-1:0]          fd_req,
  input  logic [4*NUM-1:0]        req_btype,
  output logic                    fs_send,
  input  logic                    fd_send,
  output logic [3:0]              send_btype,
  output logic [$clog2(NUM)-1:0]  grant_idx,
  output logic                    busy,
  output logic                    tmo_err
);

  localparam int IW = $clog2(NUM);

  // Valid/ready contract: every channel and the send path use a four-phase
  // level handshake (fs up, fd up, fs down, fd down); no new fs while fd is high.

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOCK = 3'd1,
    SEND = 3'd2,
    ACK  = 3'd3,
    REL  = 3'd4
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   sel_idx;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;
  logic            found;
  logic            tmo_hit;

  if (TMO == 16'd0) begin : g_tmo_chk
    $error("usb_send_arb: TMO must be nonzero");
  end

  // First requesting channel at or after ptr, wrapping around.
  always_comb begin
    pick_idx = ptr;
    cand     = '0;
    found    = 1'b0;
    for (int k = 0; k < NUM; k++) begin
      cand = ptr + IW'(k);
      if (!found && fs_req[cand]) begin
        pick_idx = cand;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (|fs_req) next_state = LOCK;
      LOCK: next_state = SEND;
      SEND: begin
        if (fd_send)      next_state = ACK;
        else if (tmo_hit) next_state = IDLE;
      end
      ACK:  if (!fd_send && !fs_req[grant_idx]) next_state = REL;
      REL:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      sel_idx    <= '0;
      grant_idx  <= '0;
      send_btype <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && (|fs_req)) sel_idx <= pick_idx;
      // Channel and block type are frozen here until the next LOCK.
      if (state == LOCK) begin
        grant_idx  <= sel_idx;
        send_btype <= req_btype[4*sel_idx +: 4];
      end
      if (state == REL || tmo_hit) ptr <= grant_idx + IW'(1);
    end
  end

  assign fs_send = (state == SEND);
  assign busy    = (state != IDLE);

  always_comb begin
    fd_req = '0;
    if (state == ACK) fd_req[grant_idx] = 1'b1;
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        tmo_q;

  // Counter is held at zero outside SEND, so it starts fresh on every entry.
  assign tmo_hit = (state == SEND) && !fd_send && (wd_cnt == TMO - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tmo_q <= tmo_hit;
      if (state != SEND) wd_cnt <= '0;
      else               wd_cnt <= wd_cnt + 16'd1;
    end
  end

  assign tmo_err = tmo_q;
`else
  assign tmo_hit = 1'b0;
  assign tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_usb_send_arb.sv
// Bench for usb_send_arb: directed scenarios plus randomized traffic against a
// round-robin grant model with an expected-grant queue.
module tb_usb_send_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  fs_req;
  logic [7:0]  fd_req;
  logic [31:0] req_btype;
  logic        fs_send;
  logic        fd_send;
  logic [3:0]  send_btype;
  logic [2:0]  grant_idx;
  logic        busy;
  logic        tmo_err;

  logic [7:0]  req_v;
  int          model_ptr;
  int          wait_cnt[8];
  logic [2:0]  exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  assign fs_req = req_v;

  usb_send_arb #(.NUM(8), .TMO(16'd16)) dut (
    .clk        (clk),
    .rst        (rst),
    .fs_req     (fs_req),
    .fd_req     (fd_req),
    .req_btype  (req_btype),
    .fs_send    (fs_send),
    .fd_send    (fd_send),
    .send_btype (send_btype),
    .grant_idx  (grant_idx),
    .busy       (busy),
    .tmo_err    (tmo_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_v = 8'h00;
    fd_send = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_ptr = 0;
    for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
  endtask

  // reference: first requester at or after the pointer, wrapping modulo 8
  function automatic int pick(input logic [7:0] m, input int p);
    for (int k = 0; k < 8; k++)
      if (m[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  // driver: one complete transfer starting from IDLE
  task automatic serve(input bit chaos, output logic [2:0] got);
    int          ch;
    int          n;
    logic [3:0]  bt;
    logic [2:0]  exp_g;
    logic [7:0]  onehot;
    bit          starved;
    ch = pick(req_v, model_ptr);
    if (ch < 0) ch = 0;
    exp_q.push_back(3'(ch));
    bt = req_btype[4*ch +: 4];
    onehot = 8'(1) << ch;
    starved = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == ch) wait_cnt[i] = 0;
      else if (req_v[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] >= 8) starved = 1'b1;
    end
    check("fairness", 32'(starved), 32'd0);

    tick();
    check("lock_fs_send", 32'(fs_send), 32'd0);
    check("lock_busy", 32'(busy), 32'd1);
    tick();
    check("send_latency", 32'(fs_send), 32'd1);
    exp_g = exp_q.pop_front();
    got = grant_idx;
    check("grant_idx", 32'(grant_idx), 32'(exp_g));
    check("send_btype", 32'(send_btype), 32'(bt));
    check("fd_req_in_send", 32'(fd_req), 32'd0);

    n = chaos ? $urandom_range(0, 3) : 0;
    for (int i = 0; i < n; i++) begin
      req_btype = $urandom;
      req_v = req_v | (8'($urandom_range(0, 255)) & ~onehot);
      if ($urandom_range(0, 3) == 0) req_v[ch] = 1'b0;
      tick();
      check("send_hold", 32'(fs_send), 32'd1);
      check("grant_stable", 32'(grant_idx), 32'(exp_g));
      check("btype_stable", 32'(send_btype), 32'(bt));
    end

    fd_send = 1'b1;
    tick();
    check("ack_fs_send", 32'(fs_send), 32'd0);
    check("ack_fd_req", 32'(fd_req), 32'(onehot));
    n = chaos ? $urandom_range(0, 2) : 0;
    for (int i = 0; i < n; i++) begin
      tick();
      check("ack_hold_fd_req", 32'(fd_req), 32'(onehot));
    end

    req_v[ch] = 1'b0;
    fd_send = 1'b0;
    tick();
    check("rel_fd_req", 32'(fd_req), 32'd0);
    check("rel_busy", 32'(busy), 32'd1);
    check("rel_btype", 32'(send_btype), 32'(bt));
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("no_tmo", 32'(tmo_err), 32'd0);
    model_ptr = (ch + 1) % 8;
  endtask

  logic [2:0] got;
  logic [2:0] order[4];

  initial begin
    req_btype = 32'h0;
    do_reset();

    // reset state
    check("rst_fs_send", 32'(fs_send), 32'd0);
    check("rst_fd_req", 32'(fd_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_idx), 32'd0);
    check("rst_btype", 32'(send_btype), 32'd0);
    check("rst_tmo", 32'(tmo_err), 32'd0);

    // single channel 2 with block type 5, then ptr=3 with channels 3 and 0
    req_btype = 32'h0000_0500;
    req_v = 8'h04;
    serve(1'b0, got);
    check("ch2_grant", 32'(got), 32'd2);
    req_v = 8'h09;
    serve(1'b0, got);
    check("ptr3_first", 32'(got), 32'd3);
    serve(1'b0, got);
    check("ptr3_second", 32'(got), 32'd0);

    // two held requesters alternate from ptr=0
    do_reset();
    order[0] = 3'd0; order[1] = 3'd7; order[2] = 3'd0; order[3] = 3'd7;
    req_v = 8'h81;
    for (int i = 0; i < 4; i++) begin
      serve(1'b0, got);
      check("alt_order", 32'(got), 32'(order[i]));
      req_v[got] = 1'b1;
    end
    req_v = 8'h00;
    tick();

    // ACK held open by fd_send and fs_req
    do_reset();
    req_v = 8'h02;
    tick();
    tick();
    fd_send = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ack36_fd_req", 32'(fd_req), 32'h02);
    end
    fd_send = 1'b0;
    tick();
    check("ack36_req_held", 32'(fd_req), 32'h02);
    req_v = 8'h00;
    tick();
    check("ack36_rel", 32'(fd_req), 32'h00);
    check("ack36_rel_busy", 32'(busy), 32'd1);
    tick();
    check("ack36_idle", 32'(busy), 32'd0);

    // reset mid-SEND
    do_reset();
    req_v = 8'h10;
    tick();
    tick();
    check("pre_rst_grant", 32'(grant_idx), 32'd4);
    check("pre_rst_send", 32'(fs_send), 32'd1);
    rst = 1'b1;
    tick();
    check("midrst_fs_send", 32'(fs_send), 32'd0);
    check("midrst_fd_req", 32'(fd_req), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_grant", 32'(grant_idx), 32'd0);
    rst = 1'b0;
    req_v = 8'h00;
    tick();

    // fd_send ignored in IDLE and LOCK
    do_reset();
    fd_send = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_fd_ignored", 32'(busy), 32'd0);
    end
    req_btype = 32'h00a0_0000;
    req_v = 8'h20;
    tick();
    check("lock_fd_ignored_send", 32'(fs_send), 32'd0);
    check("lock_fd_ignored_fd", 32'(fd_req), 32'd0);
    fd_send = 1'b0;
    tick();
    check("lock_then_send", 32'(fs_send), 32'd1);
    check("lock_then_grant", 32'(grant_idx), 32'd5);
    check("lock_then_btype", 32'(send_btype), 32'ha);
    fd_send = 1'b1;
    tick();
    check("lock_then_ack", 32'(fd_req), 32'h20);
    req_v = 8'h00;
    fd_send = 1'b0;
    tick();
    tick();
    check("lock_then_idle", 32'(busy), 32'd0);

`ifdef ARB_TIMEOUT_EN
    // watchdog abort with TMO=16
    do_reset();
    req_v = 8'h08;
    tick();
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      check("wd_no_tmo", 32'(tmo_err), 32'd0);
    end
    check("wd_still_send", 32'(fs_send), 32'd1);
    tick();
    req_v = 8'h00;
    check("wd_tmo_pulse", 32'(tmo_err), 32'd1);
    check("wd_fs_send", 32'(fs_send), 32'd0);
    check("wd_fd_req", 32'(fd_req), 32'd0);
    check("wd_idle", 32'(busy), 32'd0);
    tick();
    check("wd_tmo_one_cycle", 32'(tmo_err), 32'd0);
    req_v = 8'h18;
    serve(1'b0, got);
    check("wd_ptr_next", 32'(got), 32'd4);
    req_v = 8'h00;
    tick();
`endif

    // randomized traffic
    do_reset();
    for (int r = 0; r < 40; r++) begin
      req_btype = $urandom;
      req_v = req_v | 8'($urandom_range(0, 255));
      if (req_v == 8'h00) req_v = 8'(1) << $urandom_range(0, 7);
      serve(1'b1, got);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
